// File: rtl/stopwatch_ctrl.sv
// Start/stop stopwatch controller: synchronized and debounced button, IDLE/RUN/PAUSE
// sequencing, a seconds prescaler with BCD digits, and a lap hold on the display.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic       switch,
  output logic [1:0] state,
  output logic       second,
  output logic       minute,
  output logic [3:0] low_sec_dig,
  output logic [2:0] high_sec_dig,
  output logic       disp_hold
);
  // state | meaning
  // IDLE  | stopped, prescaler and digits cleared
  // RUN   | prescaler counting, digits advance on each tick
  // PAUSE | prescaler and digits frozen
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic        btn_s1, btn_s2, sw_s1, sw_s2;
  logic        btn_db, btn_db_d, press;
  logic [7:0]  db_cnt;
  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [3:0]  low_q, low_d, low_lat;
  logic [2:0]  high_q, high_d, high_lat;
  logic        tick, wrap, hold_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= 1'b0;
      sw_s2  <= 1'b0;
    end else begin
      btn_s1 <= button;
      btn_s2 <= btn_s1;
      sw_s1  <= switch;
      sw_s2  <= sw_s1;
    end
  end

  // db_cnt counts consecutive disagreeing cycles; any agreement restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= 8'd0;
      press    <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      press    <= btn_db & ~btn_db_d;
      if (btn_s2 != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= btn_s2;
          db_cnt <= 8'd0;
        end else begin
          db_cnt <= db_cnt + 8'd1;
        end
      end else begin
        db_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    low_d   = low_q;
    high_d  = high_q;
    tick    = 1'b0;
    wrap    = 1'b0;
    if (state_q == RUN) begin
      if (presc_q == PRESC_MAX) begin
        tick    = 1'b1;
        presc_d = 16'd0;
        if (low_q == 4'd9) begin
          low_d = 4'd0;
          if (high_q == 3'd5) begin
            high_d = 3'd0;
            wrap   = 1'b1;
          end else begin
            high_d = high_q + 3'd1;
          end
        end else begin
          low_d = low_q + 4'd1;
        end
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
    // A press on a tick edge keeps the tick's increment computed above.
    if (press) begin
      case (state_q)
        IDLE:  state_d = RUN;
        RUN:   state_d = PAUSE;
        PAUSE: begin
          if (sw_s2) begin
            state_d = IDLE;
            presc_d = 16'd0;
            low_d   = 4'd0;
            high_d  = 3'd0;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    hold_d = (state_d == RUN) && sw_s2;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= 16'd0;
      low_q     <= 4'd0;
      high_q    <= 3'd0;
      second    <= 1'b0;
      minute    <= 1'b0;
      disp_hold <= 1'b0;
      low_lat   <= 4'd0;
      high_lat  <= 3'd0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      low_q     <= low_d;
      high_q    <= high_d;
      second    <= tick;
      minute    <= wrap;
      disp_hold <= hold_d;
      // Capture the live value taken on the same edge the hold rises.
      if (hold_d && !disp_hold) begin
        low_lat  <= low_d;
        high_lat <= high_d;
      end
    end
  end

  assign state        = state_q;
  assign low_sec_dig  = disp_hold ? low_lat : low_q;
  assign high_sec_dig = disp_hold ? high_lat : high_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized button/switch
// traffic compared cycle by cycle against an elapsed-seconds reference model.
module tb_stopwatch_ctrl;
  localparam int DEB  = 4;
  localparam int TDIV = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic       switch = 1'b0;
  logic [1:0] state;
  logic       second, minute, disp_hold;
  logic [3:0] low_sec_dig;
  logic [2:0] high_sec_dig;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clock(clock), .reset(reset), .button(button), .switch(switch),
    .state(state), .second(second), .minute(minute),
    .low_sec_dig(low_sec_dig), .high_sec_dig(high_sec_dig), .disp_hold(disp_hold)
  );

  always #5 clock = ~clock;

  // Reference model: state as 0/1/2, time as elapsed seconds modulo 60.
  int m_b0, m_b1, m_s0, m_s1, m_db, m_dbd, m_run_len, m_press;
  int m_state, m_presc, m_secs, m_second, m_minute, m_hold, m_lat;

  always @(posedge clock or negedge reset) begin
    int tk, ns, nsec, nh;
    if (!reset) begin
      m_b0 = 0; m_b1 = 0; m_s0 = 0; m_s1 = 0; m_db = 0; m_dbd = 0; m_run_len = 0;
      m_press = 0; m_state = 0; m_presc = 0; m_secs = 0; m_second = 0; m_minute = 0;
      m_hold = 0; m_lat = 0;
    end else begin
      tk = (m_state == 1 && m_presc == TDIV - 1) ? 1 : 0;
      ns = m_state;
      nsec = tk ? (m_secs + 1) % 60 : m_secs;
      m_second = tk;
      m_minute = (tk && m_secs == 59) ? 1 : 0;
      if (m_state == 1) m_presc = tk ? 0 : m_presc + 1;
      if (m_press) begin
        if (m_state == 0) ns = 1;
        else if (m_state == 1) ns = 2;
        else if (m_s1) begin ns = 0; m_presc = 0; nsec = 0; end
        else ns = 1;
      end
      nh = (ns == 1 && m_s1) ? 1 : 0;
      if (nh && !m_hold) m_lat = nsec;
      m_hold = nh; m_state = ns; m_secs = nsec;
      m_press = (m_db && !m_dbd) ? 1 : 0;
      m_dbd = m_db;
      if (m_b1 != m_db) begin
        m_run_len++;
        if (m_run_len == DEB) begin m_db = m_b1; m_run_len = 0; end
      end else m_run_len = 0;
      m_b1 = m_b0; m_b0 = button;
      m_s1 = m_s0; m_s0 = switch;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; button = 1'b0; switch = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clock);
      if (state === s) break;
    end
    if (i == lim) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting state, got %b need %b", nm, state, s);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state, second, minute, low_sec_dig, high_sec_dig, disp_hold} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got st=%b sec=%b min=%b dig=%0d%0d hold=%b need all 0",
               state, second, minute, high_sec_dig, low_sec_dig, disp_hold);
    end
  endtask

  task automatic test_debounce();
    int bad, changes;
    logic [1:0] prev;
    do_reset();
    @(negedge clock);
    button = 1'b1;
    repeat (3) @(negedge clock);
    button = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clock);
      if (state !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_no_press: state left IDLE in %0d cycles, need 0", bad);
    end
    button = 1'b1;
    prev = state;
    changes = 0;
    for (int i = 0; i < 42; i++) begin
      @(negedge clock);
      if (i == 11) button = 1'b0;
      if (state !== prev) changes++;
      prev = state;
    end
    checks++;
    if (state !== 2'b01 || changes != 1) begin
      errors++;
      $display("FAIL held_press: state=%b changes=%0d need state=01 changes=1", state, changes);
    end
  endtask

  task automatic test_run_100();
    int n_sec, n_min;
    do_reset();
    @(negedge clock);
    button = 1'b1;
    wait_state(2'b01, 30, "run100_start");
    button = 1'b0;
    n_sec = 0; n_min = 0;
    repeat (100) begin
      @(negedge clock);
      if (second === 1'b1) n_sec++;
      if (minute === 1'b1) n_min++;
    end
    checks++;
    if (n_sec != 10 || n_min != 0) begin
      errors++;
      $display("FAIL run100_pulses: second=%0d minute=%0d need 10 and 0", n_sec, n_min);
    end
    checks++;
    if (high_sec_dig !== 3'd1 || low_sec_dig !== 4'd0) begin
      errors++;
      $display("FAIL run100_digits: got %0d%0d need 10", high_sec_dig, low_sec_dig);
    end
  endtask

  task automatic test_wrap();
    int i;
    for (i = 0; i < 700; i++) begin
      @(negedge clock);
      if (second === 1'b1 && high_sec_dig === 3'd5 && low_sec_dig === 4'd9) break;
    end
    checks++;
    if (i == 700) begin
      errors++;
      $display("FAIL wrap_reach59: timeout, digits %0d%0d need 59", high_sec_dig, low_sec_dig);
    end
    repeat (9) @(negedge clock);
    checks++;
    if (high_sec_dig !== 3'd5 || low_sec_dig !== 4'd9 || second !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pre: got %0d%0d sec=%b need 59 sec=0", high_sec_dig, low_sec_dig, second);
    end
    @(negedge clock);
    checks++;
    if (high_sec_dig !== 3'd0 || low_sec_dig !== 4'd0 || second !== 1'b1 || minute !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge: got %0d%0d sec=%b min=%b need 00 sec=1 min=1",
               high_sec_dig, low_sec_dig, second, minute);
    end
  endtask

  task automatic test_pause_resume();
    int i, bad, n;
    logic [3:0] lo;
    logic [2:0] hi;
    for (i = 0; i < 15; i++) begin
      @(negedge clock);
      if (second === 1'b1) break;
    end
    // Prescaler is 0 here; 9 more cycles puts the press edge at prescaler 6.
    repeat (9) @(negedge clock);
    button = 1'b1;
    wait_state(2'b10, 20, "pause_enter");
    button = 1'b0;
    lo = low_sec_dig; hi = high_sec_dig;
    checks++;
    if (int'(lo) != m_secs % 10 || int'(hi) != m_secs / 10) begin
      errors++;
      $display("FAIL pause_digits: got %0d%0d need %0d", hi, lo, m_secs);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (low_sec_dig !== lo || high_sec_dig !== hi || second !== 1'b0 || state !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pause_frozen: %0d cycles changed, need 0", bad);
    end
    button = 1'b1;
    wait_state(2'b01, 20, "resume");
    button = 1'b0;
    for (n = 0; n < 15; ) begin
      @(negedge clock);
      n++;
      if (second === 1'b1) break;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL resume_first_tick: got %0d cycles need 3", n);
    end
  endtask

  task automatic test_lap_hold();
    int i;
    do_reset();
    @(negedge clock);
    button = 1'b1;
    wait_state(2'b01, 30, "lap_start");
    button = 1'b0;
    for (i = 0; i < 120; i++) begin
      @(negedge clock);
      if (second === 1'b1 && high_sec_dig === 3'd0 && low_sec_dig === 4'd5) break;
    end
    switch = 1'b1;
    for (i = 0; i < 60; i++) begin
      @(negedge clock);
      if (m_secs == 8) break;
    end
    checks++;
    if (disp_hold !== 1'b1 || high_sec_dig !== 3'd0 || low_sec_dig !== 4'd5) begin
      errors++;
      $display("FAIL lap_held: hold=%b got %0d%0d need hold=1 05", disp_hold, high_sec_dig, low_sec_dig);
    end
    switch = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (disp_hold !== 1'b0 || high_sec_dig !== 3'd0 || low_sec_dig !== 4'd8) begin
      errors++;
      $display("FAIL lap_release: hold=%b got %0d%0d need hold=0 08", disp_hold, high_sec_dig, low_sec_dig);
    end
    button = 1'b1;
    wait_state(2'b10, 20, "lap_pause");
    button = 1'b0;
    repeat (10) @(negedge clock);
    switch = 1'b1;
    repeat (3) @(negedge clock);
    button = 1'b1;
    wait_state(2'b00, 20, "pause_to_idle");
    checks++;
    if (state !== 2'b00 || high_sec_dig !== 3'd0 || low_sec_dig !== 4'd0 || disp_hold !== 1'b0) begin
      errors++;
      $display("FAIL clear_on_press: st=%b got %0d%0d hold=%b need 00 00 0",
               state, high_sec_dig, low_sec_dig, disp_hold);
    end
    button = 1'b0;
    switch = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_async_reset();
    int i, changes;
    do_reset();
    @(negedge clock);
    button = 1'b1;
    wait_state(2'b01, 30, "areset_start");
    button = 1'b0;
    for (i = 0; i < 450; i++) begin
      @(negedge clock);
      if (high_sec_dig === 3'd3 && low_sec_dig === 4'd7) break;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({state, second, minute, low_sec_dig, high_sec_dig, disp_hold} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: st=%b sec=%b min=%b dig=%0d%0d hold=%b need all 0",
               state, second, minute, high_sec_dig, low_sec_dig, disp_hold);
    end
    button = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_state(2'b01, 30, "held_through_reset");
    changes = 0;
    repeat (20) begin
      @(negedge clock);
      if (state !== 2'b01) changes++;
    end
    checks++;
    if (changes != 0) begin
      errors++;
      $display("FAIL held_one_press: state left RUN %0d cycles, need 0", changes);
    end
    button = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_random();
    int b_left, s_left, ed;
    logic [11:0] got, exp;
    do_reset();
    b_left = 5; s_left = 20;
    repeat (3000) begin
      @(negedge clock);
      ed = m_hold ? m_lat : m_secs;
      got = {state, second, minute, low_sec_dig, high_sec_dig, disp_hold};
      exp = {2'(m_state), 1'(m_second), 1'(m_minute), 4'(ed % 10), 3'(ed / 10), 1'(m_hold)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle t=%0t: got st=%b s=%b m=%b d=%0d%0d h=%b need st=%0d s=%0d m=%0d d=%0d h=%0d",
                 $time, state, second, minute, high_sec_dig, low_sec_dig, disp_hold,
                 m_state, m_second, m_minute, ed, m_hold);
      end
      if (--b_left == 0) begin
        button = ~button;
        b_left = $urandom_range(1, 14);
      end
      if (--s_left == 0) begin
        switch = ~switch;
        s_left = $urandom_range(1, 60);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_run_100();
    test_wrap();
    test_pause_resume();
    test_lap_hold();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
